// File: rtl/softex_red_sum_acc.sv
// softex_red_sum_acc: folds the per-beat partial sums of one row into a single FP total.
// Ports:
//   clk_i, rst_i, clear_i      clock, sync active-high reset and soft clear
//   start_i, len_i, mode_i     row start, beats per row, rounding mode (RNE=0..RMM=4)
//   valid_i/strb_i/op_i/tag_i  partial-sum beat in; ready_o accepts it
//   valid_o/res_o/tag_o        row total out; ready_i accepts it
//   busy_o                     row in progress
//   status_o {nan,inf}         only with SOFTEX_RED_ACC_STATUS_EN defined
module softex_red_sum_acc #(
  parameter int EXP_BITS  = 8,
  parameter int MAN_BITS  = 23,
  parameter int LEN_WIDTH = 16,
  parameter int TAG_WIDTH = 1,
  localparam int ACC_WIDTH = EXP_BITS + MAN_BITS + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic [2:0]           mode_i,
  input  logic                 valid_i,
  input  logic                 strb_i,
  input  logic [ACC_WIDTH-1:0] op_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [ACC_WIDTH-1:0] res_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  input  logic                 ready_i,
  output logic                 busy_o
`ifdef SOFTEX_RED_ACC_STATUS_EN
  ,
  output logic [1:0]           status_o
`endif
);

  localparam int W  = MAN_BITS + 1;
  localparam int EW = EXP_BITS + 2;
  localparam int SW = W + 4;
  localparam logic [EXP_BITS-1:0] EMAX   = '1;
  localparam logic [EXP_BITS-1:0] EMAXM1 = EMAX - EXP_BITS'(1);
  localparam logic [EXP_BITS-1:0] SHMAX  = EXP_BITS'(W + 3);
  localparam logic [EW-1:0] EMAXW = EW'(EMAX);
  localparam logic [EW-1:0] ONEW  = EW'(1);
  localparam logic [ACC_WIDTH-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_BITS-1){1'b0}}};
  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  state_e state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, sum;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic beat, start;

  logic [ACC_WIDTH-1:0] x, y;
  logic swap, xs, ys, eff_sub;
  logic x_nan, y_nan, x_inf, y_inf;
  logic [EXP_BITS-1:0] xe, ye, ex_x, ex_y, diff, shamt;
  logic [W-1:0] mx, my;
  logic [2*W+6:0] ext;
  logic [SW-1:0] xa, ya, raw;
  logic [EW-1:0] ex, lz, sh, ef;
  logic [W+2:0] sig;
  logic [W:0] mr;
  logic [MAN_BITS-1:0] frac;
  logic found, inc, ovf_inf;

  // Larger magnitude goes to x so the aligned difference is never negative.
  assign swap = op_i[ACC_WIDTH-2:0] > acc_q[ACC_WIDTH-2:0];
  assign x = swap ? op_i : acc_q;
  assign y = swap ? acc_q : op_i;
  assign {xs, xe} = x[ACC_WIDTH-1:MAN_BITS];
  assign {ys, ye} = y[ACC_WIDTH-1:MAN_BITS];
  assign x_nan = (xe == EMAX) && (x[MAN_BITS-1:0] != '0);
  assign y_nan = (ye == EMAX) && (y[MAN_BITS-1:0] != '0);
  assign x_inf = (xe == EMAX) && (x[MAN_BITS-1:0] == '0);
  assign y_inf = (ye == EMAX) && (y[MAN_BITS-1:0] == '0);
  assign ex_x = (xe == '0) ? EXP_BITS'(1) : xe;
  assign ex_y = (ye == '0) ? EXP_BITS'(1) : ye;
  assign mx = {|xe, x[MAN_BITS-1:0]};
  assign my = {|ye, y[MAN_BITS-1:0]};
  assign diff = ex_x - ex_y;
  assign shamt = (diff > SHMAX) ? SHMAX : diff;

  // Bits shifted below the guard/round positions collapse into the sticky bit.
  assign ext = {1'b0, my, 3'b000, {(W+3){1'b0}}} >> shamt;
  assign ya = {ext[2*W+6:W+4], ext[W+3] | (|ext[W+2:0])};
  assign xa = {1'b0, mx, 3'b000};
  assign eff_sub = xs ^ ys;
  assign raw = eff_sub ? xa - ya : xa + ya;

  // Left shift is capped so tiny results land as subnormals at exponent 1.
  always_comb begin
    ex = EW'(ex_x);
    lz = '0;
    sh = '0;
    found = 1'b0;
    if (raw[SW-1]) begin
      sig = {raw[SW-1:2], raw[1] | raw[0]};
      ex = ex + ONEW;
    end else begin
      sig = raw[W+2:0];
      for (int i = W + 2; i >= 0; i--) begin
        if (!found) begin
          if (sig[i]) found = 1'b1;
          else lz = lz + ONEW;
        end
      end
      sh = (lz < ex - ONEW) ? lz : ex - ONEW;
      sig = sig << sh;
      ex = ex - sh;
    end
  end

  always_comb begin
    inc = sig[2] & (sig[3] | sig[1] | sig[0]);
    ovf_inf = 1'b1;
    case (mode_i)
      RTZ: begin inc = 1'b0; ovf_inf = 1'b0; end
      RDN: begin inc = (|sig[2:0]) & xs; ovf_inf = xs; end
      RUP: begin inc = (|sig[2:0]) & ~xs; ovf_inf = ~xs; end
      RMM: inc = sig[2];
      default: ;
    endcase
    mr = {1'b0, sig[W+2:3]} + (W+1)'(inc);
    if (mr[W]) begin
      ef = ex + ONEW;
      frac = mr[W-1:1];
    end else begin
      ef = mr[W-1] ? ex : '0;
      frac = mr[MAN_BITS-1:0];
    end
  end

  always_comb begin
    if (x_nan || y_nan || (x_inf && y_inf && eff_sub))
      sum = QNAN;
    else if (x_inf)
      sum = x;
    else if (raw == '0)
      sum = {eff_sub ? (mode_i == RDN) : xs, {(ACC_WIDTH-1){1'b0}}};
    else if (ef >= EMAXW)
      sum = ovf_inf ? {xs, EMAX, {MAN_BITS{1'b0}}}
                    : {xs, EMAXM1, {MAN_BITS{1'b1}}};
    else
      sum = {xs, ef[EXP_BITS-1:0], frac};
  end

  assign start = (state_q == IDLE) && start_i;
  assign beat = valid_i && ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = (len_i == '0) ? OUT : ACC;
      ACC: if (beat && cnt_q == LEN_WIDTH'(1)) state_d = OUT;
      OUT: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == ACC);
    valid_o = (state_q == OUT);
    busy_o = (state_q != IDLE);
    res_o = valid_o ? acc_q : '0;
    tag_o = valid_o ? tag_q : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      tag_q <= '0;
    end else if (start) begin
      acc_q <= '0;
      cnt_q <= len_i;
    end else if (beat) begin
      if (strb_i) acc_q <= sum;
      tag_q <= tag_i;
      cnt_q <= cnt_q - LEN_WIDTH'(1);
    end
  end

`ifdef SOFTEX_RED_ACC_STATUS_EN
  logic [1:0] stat_q;
  logic sum_nan, sum_inf;

  // Inf flags only overflow; an Inf operand passing through is not flagged.
  assign sum_nan = (sum[ACC_WIDTH-2:MAN_BITS] == EMAX)
                && (sum[MAN_BITS-1:0] != '0);
  assign sum_inf = (sum[ACC_WIDTH-2:MAN_BITS] == EMAX)
                && (sum[MAN_BITS-1:0] == '0) && !x_inf && !y_inf;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) stat_q <= '0;
    else if (start) stat_q <= '0;
    else if (beat && strb_i) stat_q <= stat_q | {sum_nan, sum_inf};
  end

  assign status_o = valid_o ? stat_q : 2'b00;
`endif

endmodule

// File: tb/tb_softex_red_sum_acc.sv
// tb_softex_red_sum_acc: directed and random rows against an exact-integer FP32 model.
// Optional status checks follow SOFTEX_RED_ACC_STATUS_EN.
module tb_softex_red_sum_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i, clear_i, start_i, valid_i, strb_i, ready_i;
  logic [15:0] len_i;
  logic [2:0] mode_i;
  logic [31:0] op_i, res_o;
  logic [0:0] tag_i, tag_o;
  logic ready_o, valid_o, busy_o;
`ifdef SOFTEX_RED_ACC_STATUS_EN
  logic [1:0] status_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  softex_red_sum_acc dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .start_i(start_i), .len_i(len_i), .mode_i(mode_i),
    .valid_i(valid_i), .strb_i(strb_i), .op_i(op_i),
    .tag_i(tag_i), .ready_o(ready_o), .valid_o(valid_o),
    .res_o(res_o), .tag_o(tag_o), .ready_i(ready_i),
    .busy_o(busy_o)
`ifdef SOFTEX_RED_ACC_STATUS_EN
    , .status_o(status_o)
`endif
  );

  task automatic chk(input string t, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", t, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // FP32 value as an exact integer count of 2^-23 units.
  function automatic longint f2i(input logic [31:0] f);
    longint s;
    int e;
    e = int'(f[30:23]);
    s = longint'(f[22:0]);
    if (e == 0) e = 1;
    else s += longint'(1) << 23;
    if (e >= 127) s = s << (e - 127);
    else s = s >>> (127 - e);
    return f[31] ? -s : s;
  endfunction

  function automatic logic [31:0] i2f(input longint v,
                                      input logic [2:0] m);
    longint n, q, rem, half;
    int p, k;
    logic neg, up;
    neg = v < 0;
    n = neg ? -v : v;
    p = 0;
    up = 1'b0;
    for (int i = 0; i < 63; i++) if (n[i]) p = i;
    if (p <= 23) begin
      q = n << (23 - p);
    end else begin
      k = p - 23;
      q = n >> k;
      rem = n - (q << k);
      half = longint'(1) << (k - 1);
      case (m)
        3'd0: up = rem > half || (rem == half && q[0]);
        3'd1: up = 1'b0;
        3'd2: up = rem != 0 && neg;
        3'd3: up = rem != 0 && !neg;
        default: up = rem >= half;
      endcase
      if (up) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    return {neg, 8'(104 + p), q[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [2:0] m);
    longint s;
    s = f2i(a) + f2i(b);
    if (s != 0) return i2f(s, m);
    if (a[30:0] == 0 && b[30:0] == 0 && a[31] == b[31])
      return {a[31], 31'b0};
    return {m == 3'd2, 31'b0};
  endfunction

  task automatic start_row(input int len);
    start_i = 1'b1;
    len_i = 16'(len);
    tick;
    start_i = 1'b0;
  endtask

  task automatic beat(input logic [31:0] op, input logic s,
                      input logic t);
    int w;
    w = 0;
    valid_i = 1'b1;
    op_i = op;
    strb_i = s;
    tag_i = t;
    while (!ready_o && w < 20) begin
      tick;
      w++;
    end
    chk("beat_ready", ready_o, 1'b1);
    tick;
    valid_i = 1'b0;
  endtask

  task automatic get_res(input string t, input logic [31:0] er,
                         input logic et, input logic [1:0] es);
    int w;
    w = 0;
    while (!valid_o && w < 50) begin
      tick;
      w++;
    end
    chk({t, "_valid"}, valid_o, 1'b1);
    chk({t, "_res"}, res_o, er);
    chk({t, "_tag"}, tag_o, et);
`ifdef SOFTEX_RED_ACC_STATUS_EN
    chk({t, "_stat"}, status_o, es);
`else
    if (es === 2'bxx) $display("unreachable");
`endif
    ready_i = 1'b1;
    tick;
    ready_i = 1'b0;
    chk({t, "_busy"}, busy_o, 1'b0);
  endtask

  task automatic sp_row(input string t, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [1:0] es);
    mode_i = m;
    start_row(2);
    beat(a, 1'b1, 1'b0);
    beat(b, 1'b1, 1'b1);
    get_res(t, er, 1'b1, es);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] acc, op, r0;
    logic t, s, last_t;
    logic [2:0] m;
    int len;

    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; len_i = '0;
    mode_i = 3'd0; valid_i = 1'b0; strb_i = 1'b0; op_i = '0;
    tag_i = '0; ready_i = 1'b0;
    repeat (2) tick;
    rst_i = 1'b0;
    tick;
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_res", res_o, 32'h0);
    chk("rst_tag", tag_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);

    // 1+2+3+4, then a stalled output with start_i pushed at it.
    start_row(4);
    chk("acc_busy", busy_o, 1'b1);
    chk("acc_ready", ready_o, 1'b1);
    chk("acc_res0", res_o, 32'h0);
    beat(32'h3F800000, 1'b1, 1'b0);
    beat(32'h40000000, 1'b1, 1'b1);
    beat(32'h40400000, 1'b1, 1'b0);
    beat(32'h40800000, 1'b1, 1'b1);
    chk("sum10_lat", valid_o, 1'b1);
    chk("sum10_res", res_o, 32'h41200000);
    chk("sum10_tag", tag_o, 1'b1);
    start_i = 1'b1;
    repeat (5) begin
      tick;
      chk("hold_valid", valid_o, 1'b1);
      chk("hold_ready", ready_o, 1'b0);
      chk("hold_res", res_o, 32'h41200000);
      chk("hold_tag", tag_o, 1'b1);
    end
    ready_i = 1'b1;
    tick;
    ready_i = 1'b0;
    start_i = 1'b0;
    chk("exit_busy", busy_o, 1'b0);
    chk("exit_valid", valid_o, 1'b0);
    chk("exit_res", res_o, 32'h0);
    tick;
    chk("exit_start_ign", busy_o, 1'b0);

    // Empty middle beat is counted but not added.
    start_row(3);
    beat(32'h40000000, 1'b1, 1'b0);
    beat(32'h41100000, 1'b0, 1'b0);
    beat(32'h3F000000, 1'b1, 1'b1);
    get_res("strb", 32'h40200000, 1'b1, 2'b00);

    // Zero-length row.
    start_row(0);
    chk("len0_valid", valid_o, 1'b1);
    chk("len0_res", res_o, 32'h0);
    chk("len0_ready", ready_o, 1'b0);
    ready_i = 1'b1;
    tick;
    ready_i = 1'b0;
    chk("len0_busy", busy_o, 1'b0);

    // Soft clear mid-row.
    start_row(4);
    beat(32'h3F800000, 1'b1, 1'b0);
    beat(32'h3F800000, 1'b1, 1'b0);
    clear_i = 1'b1;
    tick;
    clear_i = 1'b0;
    chk("clr_busy", busy_o, 1'b0);
    repeat (3) begin
      tick;
      chk("clr_valid", valid_o, 1'b0);
    end
    start_row(2);
    beat(32'h3F800000, 1'b1, 1'b0);
    beat(32'h3F800000, 1'b1, 1'b1);
    get_res("after_clr", 32'h40000000, 1'b1, 2'b00);

    // Special values and rounding boundaries.
    sp_row("inf_ninf", 3'd0, 32'h7F800000, 32'hFF800000,
           32'h7FC00000, 2'b10);
    sp_row("finite", 3'd0, 32'h3F800000, 32'h40000000,
           32'h40400000, 2'b00);
    sp_row("snan", 3'd0, 32'h7F800001, 32'h3F800000,
           32'h7FC00000, 2'b10);
    sp_row("ovf_rne", 3'd0, 32'h7F7FFFFF, 32'h7F7FFFFF,
           32'h7F800000, 2'b01);
    sp_row("ovf_rtz", 3'd1, 32'h7F7FFFFF, 32'h7F7FFFFF,
           32'h7F7FFFFF, 2'b00);
    sp_row("subn", 3'd0, 32'h00000001, 32'h00000001,
           32'h00000002, 2'b00);
    sp_row("zero_rne", 3'd0, 32'h3F800000, 32'hBF800000,
           32'h00000000, 2'b00);
    sp_row("zero_rdn", 3'd2, 32'h3F800000, 32'hBF800000,
           32'h80000000, 2'b00);
    sp_row("tie_rne", 3'd0, 32'h3F800000, 32'h33800000,
           32'h3F800000, 2'b00);
    sp_row("tie_rmm", 3'd4, 32'h3F800000, 32'h33800000,
           32'h3F800001, 2'b00);
    sp_row("tie_rup", 3'd3, 32'h3F800000, 32'h33800000,
           32'h3F800001, 2'b00);
    sp_row("tie_rdn", 3'd2, 32'hBF800000, 32'hB3800000,
           32'hBF800001, 2'b00);

    // Random rows against the exact-integer model.
    for (int r = 0; r < 60; r++) begin
      len = $urandom_range(1, 8);
      m = 3'($urandom_range(0, 4));
      mode_i = m;
      start_row(len);
      acc = 32'h0;
      last_t = 1'b0;
      for (int i = 0; i < len; i++) begin
        s = ($urandom_range(0, 3) != 0);
        t = 1'($urandom);
        if ($urandom_range(0, 7) == 0 && acc[30:0] != 0)
          op = acc ^ 32'h80000000;
        else begin
          r0 = $urandom;
          op = {r0[31], 8'(127 + $urandom_range(0, 7)), r0[22:0]};
        end
        valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) tick;
        beat(op, s, t);
        if (s) acc = ref_add(acc, op, m);
        last_t = t;
      end
      get_res("rnd", acc, last_t, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
